// File: rtl/wallace_mul_rr_sched.sv
// Round-robin scheduler sharing one 26x26 Wallace-tree multiplier among
// NUM_REQ requesters. It has a two-stage pipeline: operand register (S1) and
// product register (S2). The response channel is valid/ready with full backpressure.

// Unsigned 26x26 multiplier: partial products reduced by layers of 3:2
// carry-save adders down to two rows, then one final carry-propagate add.
module wallace_26x26 (
    input  logic [25:0] i_a,
    input  logic [25:0] i_b,
    output logic [51:0] o_z
);
    // Row count entering reduction level lvl (26 -> 18 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2)
    function automatic int rows_at(input int lvl);
        int n;
        n = 26;
        for (int k = 0; k < lvl; k++) n = 2 * (n / 3) + n % 3;
        return n;
    endfunction

    localparam int LEVELS = 7;

    logic [51:0] w_rows [LEVELS+1][26];

    generate
        // Partial products: row i is A shifted by i, gated by B[i]
        for (genvar i = 0; i < 26; i++) begin : g_pp
            assign w_rows[0][i] = i_b[i] ? (52'(i_a) << i) : 52'd0;
        end

        for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
            localparam int N = rows_at(l);
            localparam int G = N / 3;
            localparam int R = N % 3;
            localparam int M = 2 * G + R;
            // Each group of three rows becomes a sum row and a carry row. Carries
            // dropped off bit 51 are harmless: the exact product fits in 52 bits.
            for (genvar g = 0; g < G; g++) begin : g_csa
                assign w_rows[l+1][2*g]   = w_rows[l][3*g] ^ w_rows[l][3*g+1] ^ w_rows[l][3*g+2];
                assign w_rows[l+1][2*g+1] = ((w_rows[l][3*g]   & w_rows[l][3*g+1]) |
                                             (w_rows[l][3*g]   & w_rows[l][3*g+2]) |
                                             (w_rows[l][3*g+1] & w_rows[l][3*g+2])) << 1;
            end
            // Leftover rows that do not fill a group pass straight through
            for (genvar r = 0; r < R; r++) begin : g_pass
                assign w_rows[l+1][2*G+r] = w_rows[l][3*G+r];
            end
            for (genvar u = M; u < 26; u++) begin : g_zero
                assign w_rows[l+1][u] = 52'd0;
            end
        end
    endgenerate

    assign o_z = w_rows[LEVELS][0] + w_rows[LEVELS][1];
endmodule

module wallace_mul_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*26-1:0] req_a,
    input  logic [NUM_REQ*26-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [51:0]           rsp_z,
    output logic                  busy
);
    logic [ID_W-1:0] r_ptr;
    logic [25:0]     r_a, r_b;
    logic [ID_W-1:0] r_id1, r_id2;
    logic            r_v1, r_v2;
    logic [51:0]     r_z;

    logic            w_adv1, w_adv2, w_any, w_accept;
    logic [ID_W-1:0] w_gnt;
    logic [25:0]     w_a_sel, w_b_sel;
    logic [51:0]     w_prod;

    // S2 frees when empty or drained; S1 frees when empty or moving into S2
    assign w_adv2   = !r_v2 | rsp_ready;
    assign w_adv1   = !r_v1 | w_adv2;
    assign w_accept = w_any & w_adv1;

    // Round-robin scan starting at r_ptr; first asserted req_valid wins
    always_comb begin
        int idx;
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        w_any = 1'b0;
        w_gnt = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_any && req_valid[idx]) begin
                w_any = 1'b1;
                w_gnt = ID_W'(idx);
            end
        end
    end

    // One-hot ready for the winner, and its operands muxed toward S1
    always_comb begin
        req_ready = '0;
        w_a_sel   = '0;
        w_b_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt == ID_W'(i)) begin
                req_ready[i] = w_any & w_adv1;
                w_a_sel      = req_a[26*i +: 26];
                w_b_sel      = req_b[26*i +: 26];
            end
        end
    end

    wallace_26x26 u_mul (
        .i_a (r_a),
        .i_b (r_b),
        .o_z (w_prod)
    );

    // S1 operand stage and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_id1 <= '0;
            r_v1  <= 1'b0;
        end else if (w_adv1) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_v1 <= w_accept;
            if (w_accept) begin
                r_a   <= w_a_sel;
                r_b   <= w_b_sel;
                r_id1 <= w_gnt;
                r_ptr <= (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
            end
        end
    end

    // S2 product stage; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z   <= '0;
            r_id2 <= '0;
            r_v2  <= 1'b0;
        end else if (w_adv2) begin
            r_z   <= w_prod;
            r_id2 <= r_id1;
            r_v2  <= r_v1;
        end
    end

    assign rsp_valid = r_v2;
    assign rsp_id    = r_id2;
    assign rsp_z     = r_z;
    assign busy      = r_v1 | r_v2;
endmodule
